// File: rtl/ps2_digit_entry.sv
// ps2_digit_entry: right-aligned multi-digit decimal entry driven by PS/2
// key-release events. It supports digit, backspace, clear (ESC) and
// commit (ENTER), and presents the committed BCD value with a one-cycle strobe.
module ps2_digit_entry #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  SYSCLK,
  input  logic                  RST,
  input  logic [15:0]           KEY_CODE,
  input  logic                  KEY_VLD,
  output logic [4*DIGITS-1:0]   DISP_BCD,
  output logic [DIGITS-1:0]     DISP_EN,
  output logic [3:0]            DIGIT_CNT,
  output logic [4*DIGITS-1:0]   ENTRY_VAL,
  output logic                  ENTRY_VLD,
  output logic                  KEY_ERR
);

  typedef enum logic {
    IDLE  = 1'b0,
    ENTRY = 1'b1
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(DIGITS);

  state_t              state;
  logic                is_digit;
  logic                is_bksp;
  logic                is_enter;
  logic                is_esc;
  logic [4*DIGITS-1:0] digit_vec;
  logic                unused_key_bits;

  // The receiver fills bits [7:4], but only the scan code and digit nibble carry meaning.
  assign unused_key_bits = ^KEY_CODE[7:4];

  // Classify the incoming key from its scan code; nothing is decoded without KEY_VLD.
  always_comb begin
    is_digit = 1'b0;
    is_bksp  = 1'b0;
    is_enter = 1'b0;
    is_esc   = 1'b0;
    if (KEY_VLD) begin
      case (KEY_CODE[15:8])
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
        8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46: is_digit = 1'b1;
        8'h66:                             is_bksp  = 1'b1;
        8'h5A:                             is_enter = 1'b1;
        8'h76:                             is_esc   = 1'b1;
        default:                           ;
      endcase
    end
  end

  // Zero-extended digit value. Built without replication so that DIGITS=1 stays legal.
  always_comb begin
    digit_vec      = '0;
    digit_vec[3:0] = KEY_CODE[3:0];
  end

  // Leading-blank mask: enable the low DIGIT_CNT digits.
  always_comb begin
    DISP_EN = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      DISP_EN[i] = (4'(i) < DIGIT_CNT);
    end
  end

  // Entry FSM: the display, count, committed value and pulse outputs are all registered here.
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state     <= IDLE;
      DISP_BCD  <= '0;
      DIGIT_CNT <= '0;
      ENTRY_VAL <= '0;
      ENTRY_VLD <= 1'b0;
      KEY_ERR   <= 1'b0;
    end else begin
      ENTRY_VLD <= 1'b0;
      KEY_ERR   <= 1'b0;
      case (state)
        IDLE: begin
          if (is_digit) begin
            DISP_BCD  <= digit_vec;
            DIGIT_CNT <= 4'd1;
            state     <= ENTRY;
          end else if (is_enter) begin
            KEY_ERR <= 1'b1;
          end
        end
        ENTRY: begin
          if (is_digit) begin
            if (DIGIT_CNT == MAX_CNT) begin
              KEY_ERR <= 1'b1;
            end else begin
              DISP_BCD  <= (DISP_BCD << 4) | digit_vec;
              DIGIT_CNT <= DIGIT_CNT + 4'd1;
            end
          end else if (is_bksp) begin
            DISP_BCD  <= DISP_BCD >> 4;
            DIGIT_CNT <= DIGIT_CNT - 4'd1;
            if (DIGIT_CNT == 4'd1) begin
              state <= IDLE;
            end
          end else if (is_esc) begin
            DISP_BCD  <= '0;
            DIGIT_CNT <= '0;
            state     <= IDLE;
          end else if (is_enter) begin
            ENTRY_VAL <= DISP_BCD;
            ENTRY_VLD <= 1'b1;
            DISP_BCD  <= '0;
            DIGIT_CNT <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_digit_entry.sv
// Testbench for ps2_digit_entry: directed scenarios followed by random key
// streams, all checked every cycle against a queue-based entry model.
module tb_ps2_digit_entry;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic              SYSCLK;
  logic              RST;
  logic [15:0]       KEY_CODE;
  logic              KEY_VLD;
  logic [W-1:0]      DISP_BCD;
  logic [DIGITS-1:0] DISP_EN;
  logic [3:0]        DIGIT_CNT;
  logic [W-1:0]      ENTRY_VAL;
  logic              ENTRY_VLD;
  logic              KEY_ERR;

  ps2_digit_entry #(.DIGITS(DIGITS)) dut (
    .SYSCLK   (SYSCLK),
    .RST      (RST),
    .KEY_CODE (KEY_CODE),
    .KEY_VLD  (KEY_VLD),
    .DISP_BCD (DISP_BCD),
    .DISP_EN  (DISP_EN),
    .DIGIT_CNT(DIGIT_CNT),
    .ENTRY_VAL(ENTRY_VAL),
    .ENTRY_VLD(ENTRY_VLD),
    .KEY_ERR  (KEY_ERR)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: the entered digits, oldest first.
  int          q[$];
  logic [W-1:0] m_val;
  logic         m_vld;
  logic         m_err;

  logic [7:0] scan_of [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                               8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit scan_is_digit(input logic [7:0] s);
    for (int i = 0; i < 10; i++) if (scan_of[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] model_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < q.size(); i++) begin
      r = r | (W'(q[q.size() - 1 - i]) << (4 * i));
    end
    return r;
  endfunction

  task automatic model_step(input logic rst, input logic vld, input logic [15:0] code);
    m_vld = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      q.delete();
      m_val = '0;
    end else if (vld) begin
      if (scan_is_digit(code[15:8])) begin
        if (q.size() == DIGITS) m_err = 1'b1;
        else q.push_back(int'(code[3:0]));
      end else if (code[15:8] == 8'h66) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if (code[15:8] == 8'h76) begin
        q.delete();
      end else if (code[15:8] == 8'h5A) begin
        if (q.size() == 0) m_err = 1'b1;
        else begin
          m_val = model_bcd();
          m_vld = 1'b1;
          q.delete();
        end
      end
    end
  endtask

  task automatic check_all();
    int n = q.size();
    check_val("DISP_BCD",  32'(DISP_BCD),  32'(model_bcd()));
    check_val("DIGIT_CNT", 32'(DIGIT_CNT), 32'(n));
    check_val("DISP_EN",   32'(DISP_EN),   (32'd1 << n) - 32'd1);
    check_val("ENTRY_VAL", 32'(ENTRY_VAL), 32'(m_val));
    check_val("ENTRY_VLD", 32'(ENTRY_VLD), 32'(m_vld));
    check_val("KEY_ERR",   32'(KEY_ERR),   32'(m_err));
  endtask

  // Called at a negedge: drive, take one posedge, check at the following negedge.
  task automatic step(input logic rst, input logic vld, input logic [15:0] code);
    RST      = rst;
    KEY_VLD  = vld;
    KEY_CODE = code;
    @(posedge SYSCLK);
    model_step(rst, vld, code);
    @(negedge SYSCLK);
    check_all();
  endtask

  task automatic key(input logic [7:0] scan, input logic [3:0] val);
    step(1'b0, 1'b1, {scan, 4'h0, val});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0000);
  endtask

  task automatic digit(input int d);
    key(scan_of[d], 4'(d));
  endtask

  initial begin
    RST = 1'b1; KEY_VLD = 1'b0; KEY_CODE = '0;
    m_val = '0; m_vld = 1'b0; m_err = 1'b0;
    @(negedge SYSCLK);
    step(1'b1, 1'b0, 16'h0000);
    check_val("reset_bcd", 32'(DISP_BCD), 32'h0);

    // Scenario 1: 1,2,3
    digit(1); digit(2); digit(3);
    check_val("s1_bcd", 32'(DISP_BCD), 32'h0123);
    check_val("s1_en",  32'(DISP_EN),  32'b0111);
    // Scenario 2: 4, then 5 rejected when full
    digit(4);
    digit(5);
    check_val("s2_bcd", 32'(DISP_BCD), 32'h1234);
    check_val("s2_err", 32'(KEY_ERR),  32'h1);
    // Scenario 3: backspace then commit
    key(8'h66, 4'h0);
    check_val("s3_bcd", 32'(DISP_BCD), 32'h0123);
    key(8'h5A, 4'h0);
    check_val("s3_val", 32'(ENTRY_VAL), 32'h0123);
    check_val("s3_vld", 32'(ENTRY_VLD), 32'h1);
    idle();
    check_val("s3_vld_drop", 32'(ENTRY_VLD), 32'h0);
    // Scenario 4: ENTER when empty, BKSP when empty, unmapped key
    key(8'h5A, 4'h0);
    check_val("s4_err", 32'(KEY_ERR), 32'h1);
    key(8'h66, 4'h0);
    key(8'h1C, 4'h3);
    // Scenario 5: zeros then ESC
    digit(0); digit(0);
    check_val("s5_en", 32'(DISP_EN), 32'b0011);
    key(8'h76, 4'h0);
    check_val("s5_val", 32'(ENTRY_VAL), 32'h0123);
    // Scenario 6: back-to-back ENTER then digit 7
    digit(9);
    key(8'h5A, 4'h0);
    digit(7);
    check_val("s6_bcd", 32'(DISP_BCD), 32'h0007);
    // Reset together with a digit key
    step(1'b1, 1'b1, {scan_of[5], 4'h0, 4'h5});
    check_val("s6_rst_val", 32'(ENTRY_VAL), 32'h0);

    // Random key streams
    for (int i = 0; i < 3000; i++) begin
      int unsigned sel = $urandom_range(0, 99);
      logic [3:0] junk = 4'($urandom);
      logic [15:0] c;
      if (sel < 45) begin
        int d = int'($urandom_range(0, 9));
        c = {scan_of[d], junk, 4'(d)};
        step(1'b0, 1'b1, c);
      end else if (sel < 57) begin
        step(1'b0, 1'b1, {8'h66, junk, 4'($urandom)});
      end else if (sel < 69) begin
        step(1'b0, 1'b1, {8'h5A, junk, 4'($urandom)});
      end else if (sel < 74) begin
        step(1'b0, 1'b1, {8'h76, junk, 4'($urandom)});
      end else if (sel < 82) begin
        c = 16'($urandom);
        step(1'b0, 1'b1, c);
      end else if (sel < 98) begin
        step(1'b0, 1'b0, 16'($urandom));
      end else begin
        step(1'b1, 1'($urandom), 16'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
